// File: rtl/sdram_burst_arbiter.sv
// Two-client burst arbiter in front of sdram_core: read-priority grant with a write
// anti-starvation limit, plus double-buffer bank ownership swapped on vsync.
`timescale 1ns/1ps
module sdram_burst_arbiter #(
  parameter int         MAX_RD_STREAK  = 4,
  parameter logic [1:0] DRAW_BANK_INIT = 2'd1,
  parameter logic [1:0] DISP_BANK_INIT = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [9:0]  wr_len,
  input  logic [21:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_data_req,
  output logic        wr_finish,
  input  logic        rd_req,
  input  logic [9:0]  rd_len,
  input  logic [21:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_data_valid,
  output logic        rd_finish,
  input  logic        swap_req,
  input  logic        vsync_pulse,
  output logic [1:0]  draw_bank,
  output logic [1:0]  disp_bank,
  output logic        swap_pending,
  output logic        core_wr_burst_req,
  output logic [9:0]  core_wr_burst_len,
  output logic [23:0] core_wr_burst_addr,
  output logic [15:0] core_wr_burst_data,
  input  logic        core_wr_burst_data_req,
  input  logic        core_wr_burst_data_finish,
  output logic        core_rd_burst_req,
  output logic [9:0]  core_rd_burst_len,
  output logic [23:0] core_rd_burst_addr,
  input  logic [15:0] core_rd_burst_data,
  input  logic        core_rd_burst_data_valid,
  input  logic        core_rd_burst_finish
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

  logic [1:0]    state;
  logic [SW-1:0] streak;
  logic          streak_full;
  logic          grant_rd;
  logic          grant_wr;
  logic          in_wr;
  logic          in_rd;

  assign in_wr       = (state == ST_WR);
  assign in_rd       = (state == ST_RD);
  assign streak_full = (streak >= STREAK_MAX);

  // Reads win unless a pending write has already been passed over MAX_RD_STREAK times.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == ST_IDLE) begin
      if (rd_req && !(wr_req && streak_full)) begin
        grant_rd = 1'b1;
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      core_wr_burst_req  <= 1'b0;
      core_wr_burst_len  <= '0;
      core_wr_burst_addr <= '0;
      core_rd_burst_req  <= 1'b0;
      core_rd_burst_len  <= '0;
      core_rd_burst_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_rd) begin
            state              <= ST_RD;
            core_rd_burst_req  <= 1'b1;
            core_rd_burst_len  <= rd_len;
            core_rd_burst_addr <= {disp_bank, rd_addr};
          end else if (grant_wr) begin
            state              <= ST_WR;
            core_wr_burst_req  <= 1'b1;
            core_wr_burst_len  <= wr_len;
            core_wr_burst_addr <= {draw_bank, wr_addr};
          end
        end
        ST_WR: begin
          if (core_wr_burst_data_finish) begin
            state             <= ST_IDLE;
            core_wr_burst_req <= 1'b0;
          end
        end
        ST_RD: begin
          if (core_rd_burst_finish) begin
            state             <= ST_IDLE;
            core_rd_burst_req <= 1'b0;
          end
        end
        default: begin
          state             <= ST_IDLE;
          core_wr_burst_req <= 1'b0;
          core_rd_burst_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_rd && wr_req) begin
      if (!streak_full) begin
        streak <= streak + 1'b1;
      end
    end else if (grant_wr) begin
      streak <= '0;
    end else if (state == ST_IDLE && !wr_req) begin
      streak <= '0;
    end
  end

  // A swap_req coinciding with vsync swaps immediately; repeats while pending are absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_bank    <= DRAW_BANK_INIT;
      disp_bank    <= DISP_BANK_INIT;
      swap_pending <= 1'b0;
    end else if (vsync_pulse && (swap_pending || swap_req)) begin
      draw_bank    <= disp_bank;
      disp_bank    <= draw_bank;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  assign wr_data_req        = in_wr & core_wr_burst_data_req;
  assign wr_finish          = in_wr & core_wr_burst_data_finish;
  assign core_wr_burst_data = in_wr ? wr_data : 16'h0000;

  assign rd_data       = core_rd_burst_data;
  assign rd_data_valid = in_rd & core_rd_burst_data_valid;
  assign rd_finish     = in_rd & core_rd_burst_finish;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Bench for sdram_burst_arbiter: behavioural sdram_core model plus a grant scoreboard
// checking each core burst's direction, length and {bank,addr}.
`timescale 1ns/1ps
module tb_sdram_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req, swap_req, vsync_pulse;
  logic [9:0]  wr_len, rd_len;
  logic [21:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_data_req, wr_finish;
  logic [15:0] rd_data;
  logic        rd_data_valid, rd_finish;
  logic [1:0]  draw_bank, disp_bank;
  logic        swap_pending;
  logic        core_wr_burst_req;
  logic [9:0]  core_wr_burst_len;
  logic [23:0] core_wr_burst_addr;
  logic [15:0] core_wr_burst_data;
  logic        core_wr_burst_data_req = 1'b0;
  logic        core_wr_burst_data_finish = 1'b0;
  logic        core_rd_burst_req;
  logic [9:0]  core_rd_burst_len;
  logic [23:0] core_rd_burst_addr;
  logic [15:0] core_rd_burst_data = 16'h0000;
  logic        core_rd_burst_data_valid = 1'b0;
  logic        core_rd_burst_finish = 1'b0;

  sdram_burst_arbiter #(
    .MAX_RD_STREAK(4), .DRAW_BANK_INIT(2'd1), .DISP_BANK_INIT(2'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_len(wr_len), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_data_req(wr_data_req), .wr_finish(wr_finish),
    .rd_req(rd_req), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_finish(rd_finish),
    .swap_req(swap_req), .vsync_pulse(vsync_pulse),
    .draw_bank(draw_bank), .disp_bank(disp_bank), .swap_pending(swap_pending),
    .core_wr_burst_req(core_wr_burst_req), .core_wr_burst_len(core_wr_burst_len),
    .core_wr_burst_addr(core_wr_burst_addr), .core_wr_burst_data(core_wr_burst_data),
    .core_wr_burst_data_req(core_wr_burst_data_req),
    .core_wr_burst_data_finish(core_wr_burst_data_finish),
    .core_rd_burst_req(core_rd_burst_req), .core_rd_burst_len(core_rd_burst_len),
    .core_rd_burst_addr(core_rd_burst_addr), .core_rd_burst_data(core_rd_burst_data),
    .core_rd_burst_data_valid(core_rd_burst_data_valid),
    .core_rd_burst_finish(core_rd_burst_finish)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entry: {is_rd, len, {bank,addr}}
  logic [34:0] exp_q[$];
  bit          obs_seq[$];
  int rd_valid_cnt = 0, rd_fin_cnt = 0, wr_dreq_cnt = 0, wr_fin_cnt = 0;
  int bad_beats = 0, rd_beat = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  // sdram_core model: len beats then one finish pulse, driven just after each rising edge.
  bit m_rd_busy = 0, m_wr_busy = 0;
  int m_rd_cnt = 0, m_wr_cnt = 0;
  int m_rd_len = 0, m_wr_len = 0;
  always @(posedge clk) begin
    #1;
    core_rd_burst_data_valid  = 1'b0;
    core_rd_burst_finish      = 1'b0;
    core_wr_burst_data_req    = 1'b0;
    core_wr_burst_data_finish = 1'b0;
    if (!rst_n) begin
      m_rd_busy = 0;
      m_wr_busy = 0;
    end else begin
      if (m_rd_busy) begin
        if (m_rd_cnt < m_rd_len) begin
          core_rd_burst_data_valid = 1'b1;
          core_rd_burst_data = 16'hA000 + 16'(m_rd_cnt);
          m_rd_cnt++;
        end else begin
          core_rd_burst_finish = 1'b1;
          m_rd_busy = 0;
        end
      end else if (core_rd_burst_req) begin
        m_rd_busy = 1;
        m_rd_cnt  = 0;
        m_rd_len  = int'(core_rd_burst_len);
      end
      if (m_wr_busy) begin
        if (m_wr_cnt < m_wr_len) begin
          core_wr_burst_data_req = 1'b1;
          m_wr_cnt++;
        end else begin
          core_wr_burst_data_finish = 1'b1;
          m_wr_busy = 0;
        end
      end else if (core_wr_burst_req) begin
        m_wr_busy = 1;
        m_wr_cnt  = 0;
        m_wr_len  = int'(core_wr_burst_len);
      end
    end
  end

  // Monitor: pops the scoreboard on every new core burst and tallies client handshakes.
  always @(negedge clk) begin
    logic [34:0] e;
    if (core_rd_burst_req && !prev_rd) begin
      obs_seq.push_back(1'b1);
      rd_beat = 0;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_rd_unexpected: got {1,%0d,%06h} required no burst", core_rd_burst_len, core_rd_burst_addr);
      end else begin
        e = exp_q.pop_front();
        if ({1'b1, core_rd_burst_len, core_rd_burst_addr} !== e)
          $display("FAIL sb_rd_burst: got %09h required %09h", {1'b1, core_rd_burst_len, core_rd_burst_addr}, e);
        else n_pass++;
      end
    end
    if (core_wr_burst_req && !prev_wr) begin
      obs_seq.push_back(1'b0);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_wr_unexpected: got {0,%0d,%06h} required no burst", core_wr_burst_len, core_wr_burst_addr);
      end else begin
        e = exp_q.pop_front();
        if ({1'b0, core_wr_burst_len, core_wr_burst_addr} !== e)
          $display("FAIL sb_wr_burst: got %09h required %09h", {1'b0, core_wr_burst_len, core_wr_burst_addr}, e);
        else n_pass++;
      end
    end
    if (rd_data_valid === 1'b1) begin
      if (rd_data !== 16'hA000 + 16'(rd_beat)) bad_beats++;
      rd_beat++;
      rd_valid_cnt++;
    end
    if (rd_finish === 1'b1)   rd_fin_cnt++;
    if (wr_data_req === 1'b1) wr_dreq_cnt++;
    if (wr_finish === 1'b1)   wr_fin_cnt++;
    prev_rd = core_rd_burst_req;
    prev_wr = core_wr_burst_req;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_req = 0; rd_req = 0; swap_req = 0; vsync_pulse = 0;
    wr_len = '0; rd_len = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    step(3);
    n_checks++;
    if ({core_wr_burst_req, core_rd_burst_req, core_wr_burst_addr, core_rd_burst_addr} !== 50'd0)
      $display("FAIL reset_core: got req %b%b addr %06h/%06h required all 0", core_wr_burst_req, core_rd_burst_req, core_wr_burst_addr, core_rd_burst_addr);
    else n_pass++;
    n_checks++;
    if ({draw_bank, disp_bank, swap_pending} !== 5'b01_00_0)
      $display("FAIL reset_banks: got draw %0d disp %0d pend %b required 1 0 0", draw_bank, disp_bank, swap_pending);
    else n_pass++;
    n_checks++;
    if ({wr_data_req, wr_finish, rd_data_valid, rd_finish, core_wr_burst_len, core_rd_burst_len} !== 24'd0)
      $display("FAIL reset_handshake: got %b%b%b%b len %0d/%0d required 0", wr_data_req, wr_finish, rd_data_valid, rd_finish, core_wr_burst_len, core_rd_burst_len);
    else n_pass++;
    rst_n = 1'b1;
    step(2);
    $display("reset: draw=%0d disp=%0d", draw_bank, disp_bank);
  endtask

  task automatic test_read_burst;
    int t = 0;
    int v0 = rd_valid_cnt;
    int f0 = rd_fin_cnt;
    rd_addr = 22'h000100; rd_len = 10'd128;
    exp_q.push_back({1'b1, 10'd128, 24'h000100});
    rd_req = 1'b1;
    n_checks++;
    if (core_rd_burst_req !== 1'b0) $display("FAIL rd_req_early: got %b required 0", core_rd_burst_req);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (core_rd_burst_req !== 1'b1) $display("FAIL rd_req_latency: got %b required 1", core_rd_burst_req);
    else n_pass++;
    while (rd_fin_cnt == f0 && t < 1000) begin step(1); t++; end
    rd_req = 1'b0;
    n_checks++;
    if (t >= 1000) $display("FAIL rd_timeout: got no rd_finish required one within 1000 cycles");
    else n_pass++;
    step(5);
    n_checks++;
    if (rd_valid_cnt - v0 != 128) $display("FAIL rd_valid_count: got %0d required 128", rd_valid_cnt - v0);
    else n_pass++;
    n_checks++;
    if (rd_fin_cnt - f0 != 1) $display("FAIL rd_finish_count: got %0d required 1", rd_fin_cnt - f0);
    else n_pass++;
    n_checks++;
    if (bad_beats != 0) $display("FAIL rd_data: got %0d bad beats required 0", bad_beats);
    else n_pass++;
    n_checks++;
    if (core_rd_burst_req !== 1'b0) $display("FAIL rd_req_drop: got %b required 0", core_rd_burst_req);
    else n_pass++;
    $display("read burst: valids=%0d finishes=%0d", rd_valid_cnt - v0, rd_fin_cnt - f0);
  endtask

  task automatic test_write_burst;
    int t = 0;
    int d0 = wr_dreq_cnt;
    int f0 = wr_fin_cnt;
    wr_addr = 22'h000200; wr_len = 10'd100; wr_data = 16'h1234;
    exp_q.push_back({1'b0, 10'd100, 24'h400200});
    wr_req = 1'b1;
    step(3);
    n_checks++;
    if (core_wr_burst_data !== 16'h1234) $display("FAIL wr_data_fwd: got %04h required 1234", core_wr_burst_data);
    else n_pass++;
    n_checks++;
    if (core_wr_burst_addr[23:22] !== 2'b01) $display("FAIL wr_bank: got %b required 01", core_wr_burst_addr[23:22]);
    else n_pass++;
    while (wr_fin_cnt == f0 && t < 1000) begin step(1); t++; end
    wr_req = 1'b0;
    n_checks++;
    if (t >= 1000) $display("FAIL wr_timeout: got no wr_finish required one within 1000 cycles");
    else n_pass++;
    step(5);
    n_checks++;
    if (wr_dreq_cnt - d0 != 100) $display("FAIL wr_dreq_count: got %0d required 100", wr_dreq_cnt - d0);
    else n_pass++;
    n_checks++;
    if (wr_fin_cnt - f0 != 1) $display("FAIL wr_finish_count: got %0d required 1", wr_fin_cnt - f0);
    else n_pass++;
    n_checks++;
    if ({core_wr_burst_req, core_wr_burst_data} !== 17'd0)
      $display("FAIL wr_idle_outputs: got req %b data %04h required 0 0000", core_wr_burst_req, core_wr_burst_data);
    else n_pass++;
    $display("write burst: data_reqs=%0d finishes=%0d", wr_dreq_cnt - d0, wr_fin_cnt - f0);
  endtask

  task automatic test_back_to_back;
    int t = 0;
    bit exp_kind;
    obs_seq.delete();
    rd_addr = 22'h000040; rd_len = 10'd4;
    wr_addr = 22'h000080; wr_len = 10'd4;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) exp_q.push_back({1'b0, 10'd4, 24'h400080});
      else            exp_q.push_back({1'b1, 10'd4, 24'h000040});
    end
    rd_req = 1'b1; wr_req = 1'b1;
    while (obs_seq.size() < 10 && t < 2000) begin step(1); t++; end
    rd_req = 1'b0; wr_req = 1'b0;
    n_checks++;
    if (t >= 2000) $display("FAIL prio_timeout: got %0d grants required 10", obs_seq.size());
    else n_pass++;
    t = 0;
    while ((core_rd_burst_req || core_wr_burst_req) && t < 200) begin step(1); t++; end
    step(4);
    for (int i = 0; i < 10 && i < obs_seq.size(); i++) begin
      exp_kind = (i % 5 != 4);
      n_checks++;
      if (obs_seq[i] !== exp_kind)
        $display("FAIL prio_grant_%0d: got %s required %s", i, obs_seq[i] ? "RD" : "WR", exp_kind ? "RD" : "WR");
      else n_pass++;
    end
    $display("back-to-back: %0d grants observed", obs_seq.size());
  endtask

  task automatic test_swap;
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    n_checks++;
    if (swap_pending !== 1'b1) $display("FAIL swap_pending_set: got %b required 1", swap_pending);
    else n_pass++;
    step(38);
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    n_checks++;
    if ({swap_pending, draw_bank, disp_bank} !== 5'b1_01_00)
      $display("FAIL swap_hold: got pend %b draw %0d disp %0d required 1 1 0", swap_pending, draw_bank, disp_bank);
    else n_pass++;
    vsync_pulse = 1'b1; step(1); vsync_pulse = 1'b0;
    n_checks++;
    if ({swap_pending, draw_bank, disp_bank} !== 5'b0_00_01)
      $display("FAIL swap_apply: got pend %b draw %0d disp %0d required 0 0 1", swap_pending, draw_bank, disp_bank);
    else n_pass++;
    step(3);
    vsync_pulse = 1'b1; step(1); vsync_pulse = 1'b0;
    n_checks++;
    if ({swap_pending, draw_bank, disp_bank} !== 5'b0_00_01)
      $display("FAIL swap_no_request: got pend %b draw %0d disp %0d required 0 0 1", swap_pending, draw_bank, disp_bank);
    else n_pass++;
    swap_req = 1'b1; vsync_pulse = 1'b1; step(1); swap_req = 1'b0; vsync_pulse = 1'b0;
    n_checks++;
    if ({swap_pending, draw_bank, disp_bank} !== 5'b0_01_00)
      $display("FAIL swap_same_cycle: got pend %b draw %0d disp %0d required 0 1 0", swap_pending, draw_bank, disp_bank);
    else n_pass++;
    $display("swap: draw=%0d disp=%0d", draw_bank, disp_bank);
  endtask

  task automatic test_swap_mid_burst;
    int t = 0;
    int f0 = wr_fin_cnt;
    wr_addr = 22'h000010; wr_len = 10'd20;
    exp_q.push_back({1'b0, 10'd20, 24'h400010});
    wr_req = 1'b1;
    step(6);
    swap_req = 1'b1; vsync_pulse = 1'b1; step(1); swap_req = 1'b0; vsync_pulse = 1'b0;
    n_checks++;
    if (draw_bank !== 2'd0) $display("FAIL midswap_bank: got %0d required 0", draw_bank);
    else n_pass++;
    n_checks++;
    if ({core_wr_burst_req, core_wr_burst_addr} !== {1'b1, 24'h400010})
      $display("FAIL midswap_latched: got req %b addr %06h required 1 400010", core_wr_burst_req, core_wr_burst_addr);
    else n_pass++;
    while (wr_fin_cnt == f0 && t < 500) begin step(1); t++; end
    wr_req = 1'b0;
    step(3);
    exp_q.push_back({1'b0, 10'd20, 24'h000010});
    wr_req = 1'b1;
    t = 0;
    while (wr_fin_cnt < f0 + 2 && t < 500) begin step(1); t++; end
    wr_req = 1'b0;
    step(3);
    n_checks++;
    if (wr_fin_cnt - f0 != 2) $display("FAIL midswap_finishes: got %0d required 2", wr_fin_cnt - f0);
    else n_pass++;
    $display("swap mid-burst: finishes=%0d draw=%0d", wr_fin_cnt - f0, draw_bank);
  endtask

  task automatic test_reset_mid_burst;
    int f0 = rd_fin_cnt;
    rd_addr = 22'h000300; rd_len = 10'd64;
    exp_q.push_back({1'b1, 10'd64, 24'h400300});
    rd_req = 1'b1;
    step(10);
    n_checks++;
    if (core_rd_burst_req !== 1'b1) $display("FAIL rst_burst_active: got %b required 1", core_rd_burst_req);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({core_rd_burst_req, rd_data_valid, core_rd_burst_addr} !== 26'd0)
      $display("FAIL rst_async_core: got req %b valid %b addr %06h required 0 0 000000", core_rd_burst_req, rd_data_valid, core_rd_burst_addr);
    else n_pass++;
    n_checks++;
    if ({draw_bank, disp_bank, swap_pending} !== 5'b01_00_0)
      $display("FAIL rst_async_banks: got draw %0d disp %0d pend %b required 1 0 0", draw_bank, disp_bank, swap_pending);
    else n_pass++;
    rd_req = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
    n_checks++;
    if (rd_fin_cnt != f0 || core_rd_burst_req !== 1'b0)
      $display("FAIL rst_no_finish: got finishes %0d req %b required 0 0", rd_fin_cnt - f0, core_rd_burst_req);
    else n_pass++;
    $display("reset mid-burst: finishes=%0d", rd_fin_cnt - f0);
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_back_to_back();
    test_swap();
    test_swap_mid_burst();
    test_reset_mid_burst();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d unmatched bursts required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
